// File: rtl/top_module_tie_low.sv
// Tie-off cell: constant a/tie_lo/tie_hi outputs, plus an optional integrity monitor
// (sample register, heartbeat divider, saturating cycle counter, sticky error) under TIE_MONITOR_EN.
module top_module_tie_low #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int HB_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             a,
    output logic [WIDTH-1:0] tie_lo,
    output logic [WIDTH-1:0] tie_hi,
    output logic             alive,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err
);

    // The ties are driven from named nets so the monitor samples exactly what leaves the block.
    logic             a_int;
    logic [WIDTH-1:0] lo_int;
    logic [WIDTH-1:0] hi_int;

    assign a_int  = 1'b0;
    assign lo_int = '0;
    assign hi_int = '1;

    assign a      = a_int;
    assign tie_lo = lo_int;
    assign tie_hi = hi_int;

`ifdef TIE_MONITOR_EN
    localparam int DIV_W = (HB_DIV > 2) ? $clog2(HB_DIV) : 1;

    logic             samp_a_q,  samp_a_d;
    logic [WIDTH-1:0] samp_lo_q, samp_lo_d;
    logic [WIDTH-1:0] samp_hi_q, samp_hi_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic             alive_q,   alive_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             err_q,     err_d;

    always_comb begin
        samp_a_d  = a_int;
        samp_lo_d = lo_int;
        samp_hi_d = hi_int;
        // Compare runs on the registered sample, so err lags the bad edge by one cycle.
        err_d     = err_q | samp_a_q | (|samp_lo_q) | ~(&samp_hi_q);
        cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        div_d     = div_q + DIV_W'(1);
        alive_d   = alive_q;
        if (div_q == DIV_W'(HB_DIV - 1)) begin
            div_d   = '0;
            alive_d = ~alive_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a_q  <= 1'b0;
            samp_lo_q <= '0;
            samp_hi_q <= '1;
            div_q     <= '0;
            alive_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            samp_a_q  <= samp_a_d;
            samp_lo_q <= samp_lo_d;
            samp_hi_q <= samp_hi_d;
            div_q     <= div_d;
            alive_q   <= alive_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign alive     = alive_q;
    assign cycle_cnt = cnt_q;
    assign err       = err_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign alive     = 1'b0;
    assign cycle_cnt = '0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_top_module_tie_low.sv
// Self-checking bench for top_module_tie_low: tie constants, reset, counting, saturation, sticky error.
module tb_top_module_tie_low;

`ifdef TIE_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        a0, a1;
    logic [7:0]  lo0, hi0, lo1, hi1;
    logic        alive0, alive1, err0, err1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    top_module_tie_low #(.WIDTH(8), .CNT_W(16), .HB_DIV(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a0), .tie_lo(lo0), .tie_hi(hi0),
        .alive(alive0), .cycle_cnt(cnt0), .err(err0));

    top_module_tie_low #(.WIDTH(8), .CNT_W(4), .HB_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .tie_lo(lo1), .tie_hi(hi1),
        .alive(alive1), .cycle_cnt(cnt1), .err(err1));

    // Clock stays X for the first 45 ns so the ties are seen without any clock.
    initial begin
        #45 clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] cnt;
        logic        alive;
        logic        err;
        logic [3:0]  cnt1;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cnt_m, cnt1_m, div_m;
    logic        alive_m, err_m;

    task automatic model_reset();
        cnt_m = 0; cnt1_m = 0; div_m = 0; alive_m = 1'b0; err_m = 1'b0;
    endtask

    // Advance the reference model one edge, push its prediction, then compare after the edge.
    task automatic cycle();
        exp_t e, g;
        if (cnt_m < 16'hFFFF) cnt_m++;
        if (cnt1_m < 15) cnt1_m++;
        if (div_m == 15) begin div_m = 0; alive_m = ~alive_m; end
        else div_m++;
        e.cnt   = MON ? 16'(cnt_m)  : 16'd0;
        e.alive = MON ? alive_m     : 1'b0;
        e.err   = MON ? err_m       : 1'b0;
        e.cnt1  = MON ? 4'(cnt1_m)  : 4'd0;
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        n_chk++;
        if (cnt0 !== g.cnt) begin
            n_fail++; $display("FAIL cycle_cnt @%0t got %0d exp %0d", $time, cnt0, g.cnt);
        end
        n_chk++;
        if (alive0 !== g.alive) begin
            n_fail++; $display("FAIL alive @%0t got %b exp %b", $time, alive0, g.alive);
        end
        n_chk++;
        if (err0 !== g.err) begin
            n_fail++; $display("FAIL err @%0t got %b exp %b", $time, err0, g.err);
        end
        n_chk++;
        if (cnt1 !== g.cnt1) begin
            n_fail++; $display("FAIL cycle_cnt_w4 @%0t got %0d exp %0d", $time, cnt1, g.cnt1);
        end
    endtask

    task automatic check_idle(input string tag);
        n_chk++;
        if (cnt0 !== 16'd0 || alive0 !== 1'b0 || err0 !== 1'b0 || cnt1 !== 4'd0) begin
            n_fail++;
            $display("FAIL %s got cnt=%0d alive=%b err=%b cnt4=%0d exp all 0", tag, cnt0, alive0, err0, cnt1);
        end
    endtask

    task automatic test_ties();
        for (int t = 0; t < 5; t++) begin
            #1;
            n_chk++;
            if (a0 !== 1'b0 || a1 !== 1'b0) begin
                n_fail++; $display("FAIL tie_a @%0t got %b/%b exp 0", $time, a0, a1);
            end
            n_chk++;
            if (lo0 !== 8'h00 || hi0 !== 8'hFF || lo1 !== 8'h00 || hi1 !== 8'hFF) begin
                n_fail++; $display("FAIL tie_bus @%0t lo=%h hi=%h exp 00/ff", $time, lo0, hi0);
            end
            #7;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1 check_idle("reset_state");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_40();
        for (int i = 0; i < 40; i++) cycle();
        n_chk++;
        if (cnt0 !== (MON ? 16'd40 : 16'd0) || alive0 !== 1'b0) begin
            n_fail++; $display("FAIL count40 got cnt=%0d alive=%b exp %0d/0", cnt0, alive0, MON ? 40 : 0);
        end
    endtask

    task automatic test_saturate();
        test_reset();
        for (int i = 0; i < 20; i++) cycle();
        n_chk++;
        if (cnt1 !== (MON ? 4'd15 : 4'd0)) begin
            n_fail++; $display("FAIL saturate got %0d exp %0d", cnt1, MON ? 15 : 0);
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        for (int i = 0; i < 10; i++) cycle();
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_err();
        test_reset();
        for (int i = 0; i < 3; i++) cycle();
        force dut0.a_int = 1'b1;
        cycle();
        release dut0.a_int;
        err_m = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        rst_n = 1'b0;
        #1 check_idle("err_cleared");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        test_ties();
        test_reset();
        test_count_40();
        test_saturate();
        test_mid_reset();
        test_err();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/top_module_tie_low.md
# top_module_tie_low

Constant tie-off cell driving a guaranteed logic-0 on output `a`, plus fixed all-zero/all-one tie buses for unused inputs elsewhere in the design. The tie outputs are purely combinational and valid from time zero without clock or reset. An optional clocked integrity monitor samples the ties and reports liveness and sticky error status. The block sits at top level wherever hard tie-offs with observability are needed.

## Interface
Parameters:
- `WIDTH`, 8, width of `tie_lo` / `tie_hi` buses (≥1)
- `CNT_W`, 16, width of `cycle_cnt` (≥2)
- `HB_DIV`, 16, clock cycles per `alive` toggle (≥2)

Ports:
- `clk`  input  1  monitor clock; only clock in the block
- `rst_n`  input  1  reset, asynchronous, active-low
- `a`  output  1  constant logic 0
- `tie_lo`  output  WIDTH  constant all-zero bus
- `tie_hi`  output  WIDTH  constant all-one bus
- `alive`  output  1  heartbeat, toggles every HB_DIV cycles
- `cycle_cnt`  output  CNT_W  saturating count of clock cycles since reset release
- `err`  output  1  sticky: a tie output was sampled at a wrong value

## Operation
- `a` = 0, `tie_lo` = all 0, `tie_hi` = all 1: continuous combinational constants, no dependency on `clk`, `rst_n` or any state.
- Constants hold when `clk`/`rst_n` are X, Z, unconnected, or never toggled.
- Monitor (when compiled in):
  - Sample register captures {`a`, `tie_lo`, `tie_hi`} each rising `clk`.
  - `err` sets when sampled `a` ≠ 0, any `tie_lo` bit ≠ 0, or any `tie_hi` bit ≠ 1; stays set until reset.
  - `cycle_cnt` increments by 1 per cycle; saturates at 2^CNT_W−1, no wrap.
  - Divider counts 0..HB_DIV−1; on reaching HB_DIV−1 it returns to 0 and `alive` inverts.
- No handshakes, no FSM beyond the divider.

## Timing
- Tie outputs: zero latency, valid at simulation time 0.
- Reset (`rst_n`=0, async): `alive`=0, `cycle_cnt`=0, `err`=0, divider=0, sample register=expected constants; takes effect immediately, mid-operation included.
- After release: first rising edge makes `cycle_cnt`=1; `alive` first goes 1 at edge HB_DIV and toggles every HB_DIV edges after.
- `err` rises one cycle after the offending sample edge (sample + compare registered).
- Reset has priority over all clocked updates on the same edge.

## Configuration
- `TIE_MONITOR_EN` defined: monitor logic (sample register, divider, counter, error flag) compiled in as above.
- Not defined: no flops; `alive`, `cycle_cnt`, `err` tied to 0; `clk`/`rst_n` unused. Tie outputs identical in both builds.

## Test plan
- No clock, `rst_n` undriven, 0–40 ns -> `a`=0 continuously, mismatch against expected 0 never asserted.
- WIDTH=8, any time -> `tie_lo`=8'h00, `tie_hi`=8'hFF; X on `clk`/`rst_n` does not disturb them.
- Monitor on, reset then 40 cycles, HB_DIV=16 -> `cycle_cnt`=40, `alive` toggled at edges 16 and 32 (now 0), `err`=0.
- CNT_W=4, 20 cycles -> `cycle_cnt` holds 15 from edge 15 onward.
- Assert `rst_n`=0 between edges after 10 cycles -> `cycle_cnt`, `alive`, `err` go 0 immediately; after release counting restarts at 1.
- Force sampled `a` to 1 for one cycle -> `err`=1 next cycle and stays 1 until reset; with `TIE_MONITOR_EN` undefined `err` stays 0.
